// File: rtl/ibex_topdown_counter_bank_if.sv
// Register port bundle for the top-down counter bank: single-cycle request,
// fixed one-cycle response.
interface ibex_topdown_counter_bank_if #(
    parameter int AddrWidth = 8
);
    logic                 req;
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic                 rvalid;
    logic [31:0]          rdata;
    logic                 err;

    modport master (output req, we, addr, wdata, input rvalid, rdata, err);
    modport slave  (input req, we, addr, wdata, output rvalid, rdata, err);
endinterface

// File: rtl/ibex_topdown_counter_bank.sv
// Bank of top-down performance event counters with atomic wide reads, overflow irq
// and optional snapshot capture (enabled by defining IBEX_TOPDOWN_SNAPSHOT_EN).
module ibex_topdown_counter_bank #(
    parameter int NumCounters  = 8,
    parameter int CounterWidth = 40,
    parameter int NumEvents    = 16,
    parameter int AddrWidth    = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumEvents-1:0]       event_i,
    input  logic                       snapshot_i,
    ibex_topdown_counter_bank_if.slave bus,
    output logic                       irq_o
);
    localparam int HiWidth  = CounterWidth - 32;
    localparam int SnapBase = 4 + 4 * NumCounters;
    localparam int MapEnd   = 4 + 6 * NumCounters;

    logic                                     ctrl_en, ctrl_irq_en;
    logic [NumCounters-1:0]                   inhibit, ovf, ovf_set;
    logic [NumCounters-1:0][CounterWidth-1:0] cnt;
    logic [NumCounters-1:0][7:0]              sel;
    logic [NumCounters-1:0]                   wr_lo, wr_hi, wr_sel, rd_lo;
    logic [HiWidth-1:0]                       hi_latch;
    logic [4:0]                               latch_idx;
    logic                                     latch_vld;
    logic [AddrWidth-1:0]                     addr_raw;
    logic [31:0]                              addr, cnt_off, rdata_d;
    logic                                     err_d, wr, rd, cnt_region;
    logic [255:0]                             ev_ext;

    assign addr_raw   = bus.addr;
    assign addr       = 32'(addr_raw);
    assign wr         = bus.req & bus.we;
    assign rd         = bus.req & ~bus.we;
    assign cnt_region = (addr >= 32'd4) && (addr < 32'(SnapBase));
    assign cnt_off    = addr - 32'd4;
    assign ev_ext     = 256'(event_i);

`ifdef IBEX_TOPDOWN_SNAPSHOT_EN
    logic [NumCounters-1:0][CounterWidth-1:0] snap;
    logic [31:0]                              snap_off;
    logic                                     snap_region, snap_trig;
    assign snap_region = (addr >= 32'(SnapBase)) && (addr < 32'(MapEnd));
    assign snap_off    = addr - 32'(SnapBase);
    assign snap_trig   = snapshot_i | (wr && addr == 32'd0 && bus.wdata[2]);
`else
    logic unused_snapshot;
    assign unused_snapshot = snapshot_i;
`endif

    always_comb begin
        wr_lo  = '0;
        wr_hi  = '0;
        wr_sel = '0;
        rd_lo  = '0;
        for (int i = 0; i < NumCounters; i++) begin
            if (cnt_region && cnt_off[31:2] == 30'(i)) begin
                wr_lo[i]  = wr && cnt_off[1:0] == 2'd0;
                wr_hi[i]  = wr && cnt_off[1:0] == 2'd1;
                wr_sel[i] = wr && cnt_off[1:0] == 2'd2;
                rd_lo[i]  = rd && cnt_off[1:0] == 2'd0;
            end
        end
    end

    // Read mux works on pre-edge state, so a counter read excludes this cycle's event.
    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (addr == 32'd0) begin
            rdata_d = 32'({ctrl_irq_en, ctrl_en});
        end else if (addr == 32'd1) begin
            rdata_d = 32'(inhibit);
        end else if (addr == 32'd2) begin
            rdata_d = 32'(ovf);
        end else if (cnt_region) begin
            for (int i = 0; i < NumCounters; i++) begin
                if (cnt_off[31:2] == 30'(i)) begin
                    case (cnt_off[1:0])
                        2'd0:    rdata_d = cnt[i][31:0];
                        2'd1:    rdata_d = (latch_vld && latch_idx == 5'(i)) ? 32'(hi_latch)
                                                                             : 32'(cnt[i][CounterWidth-1:32]);
                        2'd2:    rdata_d = 32'(sel[i]);
                        default: rdata_d = '0;
                    endcase
                end
            end
`ifdef IBEX_TOPDOWN_SNAPSHOT_EN
        end else if (snap_region) begin
            for (int i = 0; i < NumCounters; i++) begin
                if (snap_off[31:1] == 31'(i)) begin
                    rdata_d = snap_off[0] ? 32'(snap[i][CounterWidth-1:32]) : snap[i][31:0];
                end
            end
`endif
        end else if (addr >= 32'(MapEnd)) begin
            err_d = 1'b1;
        end
    end

    for (genvar g = 0; g < NumCounters; g++) begin : g_cnt
        logic [CounterWidth-1:0] c_q;
        logic [7:0]              s_q;
        logic [CounterWidth:0]   sum;
        logic                    hit;

        assign hit = ctrl_en & ~inhibit[g] & (s_q < 8'(NumEvents)) & ev_ext[s_q];
        assign sum = {1'b0, c_q} + (CounterWidth + 1)'(1);
        // A software write to the counter swallows both the increment and its overflow.
        assign ovf_set[g] = hit & sum[CounterWidth] & ~(wr_lo[g] | wr_hi[g]);
        assign cnt[g] = c_q;
        assign sel[g] = s_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                c_q <= '0;
                s_q <= 8'hFF;
            end else begin
                if (wr_lo[g])      c_q[31:0]              <= bus.wdata;
                else if (wr_hi[g]) c_q[CounterWidth-1:32] <= bus.wdata[HiWidth-1:0];
                else if (hit)      c_q                    <= sum[CounterWidth-1:0];
                if (wr_sel[g])     s_q                    <= bus.wdata[7:0];
            end
        end

`ifdef IBEX_TOPDOWN_SNAPSHOT_EN
        logic [CounterWidth-1:0] snap_q;
        assign snap[g] = snap_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)        snap_q <= '0;
            else if (snap_trig) snap_q <= c_q;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.err     <= 1'b0;
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            inhibit     <= '0;
            ovf         <= '0;
            irq_o       <= 1'b0;
            hi_latch    <= '0;
            latch_idx   <= '0;
            latch_vld   <= 1'b0;
        end else begin
            bus.rvalid <= bus.req;
            bus.rdata  <= rd ? rdata_d : '0;
            bus.err    <= bus.req & err_d;
            if (wr && addr == 32'd0) begin
                ctrl_en     <= bus.wdata[0];
                ctrl_irq_en <= bus.wdata[1];
            end
            if (wr && addr == 32'd1) inhibit <= bus.wdata[NumCounters-1:0];
            // New overflow beats a same-cycle write-1-clear.
            ovf   <= (ovf & ~((wr && addr == 32'd2) ? bus.wdata[NumCounters-1:0] : '0)) | ovf_set;
            irq_o <= ctrl_irq_en & (|ovf);
            if (|(wr_lo | wr_hi)) begin
                latch_vld <= 1'b0;
            end else if (|rd_lo) begin
                latch_vld <= 1'b1;
                for (int i = 0; i < NumCounters; i++) begin
                    if (rd_lo[i]) begin
                        hi_latch  <= cnt[i][CounterWidth-1:32];
                        latch_idx <= 5'(i);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ibex_topdown_counter_bank.sv
// Scoreboard bench for ibex_topdown_counter_bank: directed scenarios plus random
// traffic, checked against a per-cycle behavioural model of the register map.
module tb_ibex_topdown_counter_bank;
    localparam int N  = 8;
    localparam int CW = 40;
    localparam int NE = 16;
    localparam int AW = 8;
    localparam int SB = 4 + 4 * N;
    localparam int ME = 4 + 6 * N;
    localparam longint unsigned MASK = (64'd1 << CW) - 1;
    localparam longint unsigned LO32 = 64'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NE-1:0] ev = '0;
    logic          snap_in = 1'b0;
    logic          irq;

    ibex_topdown_counter_bank_if #(.AddrWidth(AW)) bus ();

    ibex_topdown_counter_bank #(
        .NumCounters(N), .CounterWidth(CW), .NumEvents(NE), .AddrWidth(AW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .event_i(ev), .snapshot_i(snap_in), .bus(bus), .irq_o(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t rq[$];
    bit   iq[$];

    longint unsigned m_cnt[N];
    longint unsigned m_snap[N];
    int              m_sel[N];
    bit              m_en, m_irqen, m_lv;
    bit [N-1:0]      m_inh, m_ovf;
    longint unsigned m_hil;
    int              m_lidx;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_snap[i] = 0; m_sel[i] = 8'hFF;
        end
        m_en = 0; m_irqen = 0; m_lv = 0; m_inh = '0; m_ovf = '0; m_hil = 0; m_lidx = -1;
        rq.delete(); iq.delete();
    endfunction

    function automatic rsp_t model_read(int a, bit is_read);
        rsp_t r;
        longint unsigned v;
        r.rdata = '0;
        r.err   = (a >= ME);
        if (!is_read || r.err) return r;
        if (a == 0) r.rdata = {30'd0, m_irqen, m_en};
        else if (a == 1) r.rdata = 32'(m_inh);
        else if (a == 2) r.rdata = 32'(m_ovf);
        else if (a >= 4 && a < SB) begin
            int i = (a - 4) / 4;
            case ((a - 4) % 4)
                0: r.rdata = 32'(m_cnt[i] & LO32);
                1: begin
                    v = (m_lv && m_lidx == i) ? m_hil : (m_cnt[i] >> 32);
                    r.rdata = 32'(v);
                end
                2: r.rdata = 32'(m_sel[i]);
                default: r.rdata = '0;
            endcase
        end
`ifdef IBEX_TOPDOWN_SNAPSHOT_EN
        else if (a >= SB && a < ME) begin
            int j = (a - SB) / 2;
            r.rdata = ((a - SB) % 2 == 1) ? 32'(m_snap[j] >> 32) : 32'(m_snap[j] & LO32);
        end
`endif
        return r;
    endfunction

    // Drive one cycle at a negedge, record expectations, advance the model over the edge.
    task automatic cycle(bit req, bit we, int a, logic [31:0] wd, logic [NE-1:0] e, bit sn);
        bit [N-1:0] nset;
        bit wlo, whi;
        nset = '0;
        bus.req = req; bus.we = we; bus.addr = AW'(a); bus.wdata = wd; ev = e; snap_in = sn;
        if (req) rq.push_back(model_read(a, !we));
        iq.push_back(m_irqen && (m_ovf != 0));
`ifdef IBEX_TOPDOWN_SNAPSHOT_EN
        if (sn || (req && we && a == 0 && wd[2])) for (int i = 0; i < N; i++) m_snap[i] = m_cnt[i];
`endif
        if (req && !we && a >= 4 && a < SB && (a - 4) % 4 == 0) begin
            m_lidx = (a - 4) / 4; m_hil = m_cnt[m_lidx] >> 32; m_lv = 1;
        end
        for (int i = 0; i < N; i++) begin
            wlo = req && we && a == 4 + 4 * i;
            whi = req && we && a == 5 + 4 * i;
            if (wlo || whi) m_lv = 0;
            if (wlo) m_cnt[i] = (m_cnt[i] & ~LO32) | 64'(wd);
            else if (whi) m_cnt[i] = (m_cnt[i] & LO32) | ((64'(wd) & (MASK >> 32)) << 32);
            else if (m_en && !m_inh[i] && m_sel[i] < NE && e[m_sel[i]]) begin
                if (m_cnt[i] == MASK) begin m_cnt[i] = 0; nset[i] = 1; end
                else m_cnt[i]++;
            end
            if (req && we && a == 6 + 4 * i) m_sel[i] = int'(wd[7:0]);
        end
        if (req && we && a == 2) m_ovf &= ~wd[N-1:0];
        m_ovf |= nset;
        if (req && we && a == 0) begin m_en = wd[0]; m_irqen = wd[1]; end
        if (req && we && a == 1) m_inh = wd[N-1:0];
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(bit abort);
        if (abort) begin
            bus.req = 1; bus.we = 0; bus.addr = AW'(4);
            #2;
        end
        rst_n = 0;
        model_reset();
        bus.req = 0; bus.we = 0; ev = '0; snap_in = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rvalid", 32'(bus.rvalid), 0);
        chk("reset_rdata", bus.rdata, 0);
        chk("reset_err", 32'(bus.err), 0);
        chk("reset_irq", 32'(irq), 0);
        @(negedge clk);
        rst_n = 1;
    endtask

    always @(posedge clk) begin
        rsp_t r;
        bit   ei;
        #1;
        if (rst_n) begin
            if (iq.size() > 0) begin
                ei = iq.pop_front();
                chk("irq", 32'(irq), 32'(ei));
            end
            if (bus.rvalid) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rvalid got=1 exp=0 at %0t", $time);
                end else begin
                    r = rq.pop_front();
                    chk("rdata", bus.rdata, r.rdata);
                    chk("err", 32'(bus.err), 32'(r.err));
                end
            end else if (rq.size() > 0) begin
                total++; bad++;
                void'(rq.pop_front());
                $display("FAIL missing_rvalid got=0 exp=1 at %0t", $time);
            end
        end
    end

    initial begin
        int a;
        logic [31:0] wd;
        bus.req = 0; bus.we = 0; bus.addr = '0; bus.wdata = '0;
        model_reset();
        @(negedge clk);
        do_reset(0);
        cycle(1, 0, 6, 0, 0, 0);                       // SEL[0] reset value
        cycle(1, 0, 0, 0, 0, 0);                       // CTRL reset value
        cycle(1, 1, 6, 3, 0, 0);
        cycle(1, 1, 0, 1, 0, 0);
        repeat (10) cycle(0, 0, 0, 0, 16'h0008, 0);
        cycle(1, 0, 4, 0, 0, 0);
        cycle(1, 0, 5, 0, 0, 0);
        // Counter 1 wrap, irq, and set-beats-clear on OVF.
        cycle(1, 1, 10, 5, 0, 0);
        cycle(1, 1, 9, 32'hFF, 0, 0);
        cycle(1, 1, 8, 32'hFFFF_FFFF, 0, 0);
        cycle(1, 1, 0, 3, 0, 0);
        cycle(0, 0, 0, 0, 16'h0020, 0);
        cycle(1, 0, 8, 0, 0, 0);
        cycle(1, 0, 9, 0, 0, 0);
        cycle(1, 0, 2, 0, 0, 0);
        cycle(1, 1, 9, 32'hFF, 0, 0);
        cycle(1, 1, 8, 32'hFFFF_FFFF, 0, 0);
        cycle(1, 1, 2, 2, 16'h0020, 0);
        cycle(1, 0, 2, 0, 0, 0);
        cycle(1, 1, 2, 2, 0, 0);
        cycle(1, 0, 2, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // Atomic wide read across a wrap of counter 2.
        cycle(1, 1, 14, 7, 0, 0);
        cycle(1, 1, 13, 32'hFF, 0, 0);
        cycle(1, 1, 12, 32'hFFFF_FFFF, 16'h0080, 0);
        cycle(1, 0, 12, 0, 16'h0080, 0);
        cycle(1, 0, 13, 0, 0, 0);
        cycle(1, 0, 12, 0, 0, 0);
        // Snapshot of counter 0 while it counts.
        cycle(1, 1, 4, 5, 0, 0);
        cycle(1, 1, 5, 0, 0, 0);
        cycle(0, 0, 0, 0, 16'h0008, 1);
        cycle(1, 0, SB, 0, 0, 0);
        cycle(1, 0, 4, 0, 0, 0);
        cycle(1, 1, 0, 32'h7, 16'h0008, 0);
        cycle(1, 0, SB + 1, 0, 0, 0);
        // Unmapped accesses.
        cycle(1, 0, 255, 0, 0, 0);
        cycle(1, 1, 255, 32'h1234, 0, 0);
        cycle(1, 0, ME, 0, 0, 0);
        cycle(1, 0, 3, 0, 0, 0);
        // Random traffic.
        repeat (600) begin
            a = ($urandom % 8 == 0) ? int'($urandom % 256) : int'($urandom % ME);
            wd = ($urandom % 3 == 0) ? 32'hFFFF_FFFF : $urandom;
            if (a >= 4 && a < SB && (a - 4) % 4 == 2) wd = $urandom % 20;
            if (a == 0 && $urandom % 2 == 0) wd[0] = 1'b1;
            cycle($urandom % 4 != 0, $urandom % 2 == 1, a, wd, NE'($urandom), $urandom % 16 == 0);
        end
        // Reset mid-count with an access in flight.
        cycle(1, 1, 0, 1, 0, 0);
        cycle(1, 1, 6, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0, 16'h0001, 0);
        do_reset(1);
        for (int i = 0; i < N; i++) begin
            cycle(1, 0, 4 + 4 * i, 0, 0, 0);
            cycle(1, 0, 5 + 4 * i, 0, 0, 0);
        end
        cycle(1, 0, 6, 0, 0, 0);
        cycle(1, 0, 2, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
